// File: rtl/univ_shift_reg.sv
// Parametrised load/shift register with five shift/rotate modes, serial in/out
// and a multi-step shift engine driven by a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for ld, start or shEn
// SHIFT | one step per edge using the latched mode, counter counts down
// DONE  | one-cycle completion pulse, then back to IDLE
module univ_shift_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             shEn,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             serIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             serOut,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] M_SLL = 3'd0;
  localparam logic [2:0] M_SRL = 3'd1;
  localparam logic [2:0] M_SRA = 3'd2;
  localparam logic [2:0] M_ROL = 3'd3;
  localparam logic [2:0] M_ROR = 3'd4;

  logic [1:0]       state;
  logic [WIDTH-1:0] data;
  logic             ser_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] step_data;
  logic             step_out;
  logic             mode_ok;

  assign mode_ok = (mode <= M_ROR);

  // One step of the latched operation; the reserved encodings never get latched.
  always_comb begin
    step_data = data;
    step_out  = ser_q;
    case (mode_q)
      M_SLL: begin
        step_data = {data[WIDTH-2:0], serIn};
        step_out  = data[WIDTH-1];
      end
      M_SRL: begin
        step_data = {serIn, data[WIDTH-1:1]};
        step_out  = data[0];
      end
      M_SRA: begin
        step_data = {data[WIDTH-1], data[WIDTH-1:1]};
        step_out  = data[0];
      end
      M_ROL: begin
        step_data = {data[WIDTH-2:0], data[WIDTH-1]};
        step_out  = data[WIDTH-1];
      end
      M_ROR: begin
        step_data = {data[0], data[WIDTH-1:1]};
        step_out  = data[0];
      end
      default: begin
        step_data = data;
        step_out  = ser_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      data   <= '0;
      ser_q  <= 1'b0;
      cnt    <= '0;
      mode_q <= M_SLL;
    end else if (ld) begin
      // Load aborts any running operation silently; serOut keeps its value.
      data  <= dataIn;
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && mode_ok) begin
            mode_q <= mode;
            if (amount != '0) begin
              cnt   <= amount;
              state <= S_SHIFT;
            end else begin
              state <= S_DONE;
            end
          end else if (!start && shEn) begin
            data  <= {data[WIDTH-2:0], serIn};
            ser_q <= data[WIDTH-1];
          end
        end
        S_SHIFT: begin
          data  <= step_data;
          ser_q <= step_out;
          cnt   <= cnt - 1'b1;
          if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign dataOut = data;
  assign serOut  = ser_q;
  assign busy    = (state == S_SHIFT);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: expected results are queued when an
// operation is started and compared when the done pulse appears.
module tb_univ_shift_reg;
  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld;
  logic [W-1:0]  dataIn;
  logic          shEn;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] amount;
  logic          serIn;
  logic [W-1:0]  dataOut;
  logic          serOut;
  logic          busy;
  logic          done;

  int   total = 0;
  int   bad   = 0;
  logic last_ser;

  typedef struct {
    logic [W-1:0] d;
    logic         s;
    int           n;
  } exp_t;
  exp_t sb[$];

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ld(ld), .dataIn(dataIn), .shEn(shEn),
    .start(start), .mode(mode), .amount(amount), .serIn(serIn),
    .dataOut(dataOut), .serOut(serOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    ld = 1'b1;
    dataIn = v;
    tick();
    ld = 1'b0;
  endtask

  // Independent step-by-step reference for the randomised operations.
  function automatic void model_op(input logic [W-1:0] d, input logic s, input logic [2:0] m,
                                   input int n, input logic sin,
                                   output logic [W-1:0] od, output logic os);
    od = d;
    os = s;
    for (int i = 0; i < n; i++) begin
      case (m)
        3'd0: begin os = od[W-1]; od = od << 1; od[0] = sin; end
        3'd1: begin os = od[0]; od = od >> 1; od[W-1] = sin; end
        3'd2: begin os = od[0]; od = $signed(od) >>> 1; end
        3'd3: begin os = od[W-1]; od = (od << 1) | (od >> (W-1)); end
        default: begin os = od[0]; od = (od >> 1) | (od << (W-1)); end
      endcase
    end
  endfunction

  task automatic run_op(input logic [2:0] m, input logic [CW-1:0] n, input logic [W-1:0] ed,
                        input logic es, input logic with_sh, input string name);
    exp_t e;
    int nb;
    int cyc;
    e.d = ed;
    e.s = es;
    e.n = int'(n);
    sb.push_back(e);
    start = 1'b1;
    mode = m;
    amount = n;
    shEn = with_sh;
    tick();
    start = 1'b0;
    shEn = 1'b0;
    mode = 3'd7;
    amount = '0;
    nb = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 64) begin
      if (busy === 1'b1) nb++;
      tick();
      cyc++;
    end
    e = sb.pop_front();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL %s done: got %b exp 1 (timeout)", name, done); end
    total++;
    if (nb != e.n) begin bad++; $display("FAIL %s busy_cycles: got %0d exp %0d", name, nb, e.n); end
    total++;
    if (cyc != e.n) begin bad++; $display("FAIL %s done_latency: got %0d exp %0d", name, cyc, e.n); end
    total++;
    if (dataOut !== e.d) begin bad++; $display("FAIL %s dataOut: got %h exp %h", name, dataOut, e.d); end
    total++;
    if (serOut !== e.s) begin bad++; $display("FAIL %s serOut: got %b exp %b", name, serOut, e.s); end
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL %s done_pulse_len: got %b exp 0", name, done); end
    last_ser = es;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++;
    if ({dataOut, serOut, busy, done} !== '0) begin
      bad++; $display("FAIL reset_init: got %h/%b/%b/%b exp 0", dataOut, serOut, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    load(16'hA5C3);
    start = 1'b1; mode = 3'd0; amount = 5'd10;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({dataOut, serOut, busy, done} !== '0) begin
      bad++; $display("FAIL reset_async: got %h/%b/%b/%b exp 0", dataOut, serOut, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    last_ser = 1'b0;
  endtask

  task automatic test_sll;
    serIn = 1'b0;
    load(16'hA5C3);
    run_op(3'd0, 5'd4, 16'h5C30, 1'b0, 1'b0, "sll4");
  endtask

  task automatic test_ror_sra;
    load(16'h1234);
    run_op(3'd4, 5'd8, 16'h3412, 1'b0, 1'b0, "ror8");
    load(16'h8010);
    run_op(3'd2, 5'd3, 16'hF002, 1'b0, 1'b0, "sra3");
  endtask

  task automatic test_boundary;
    load(16'h5A5A);
    run_op(3'd1, 5'd0, 16'h5A5A, last_ser, 1'b0, "amount0");
    load(16'h0001);
    run_op(3'd3, 5'd17, 16'h0002, 1'b0, 1'b0, "rol17");
    load(16'h00F0);
    serIn = 1'b1;
    run_op(3'd0, 5'd20, 16'hFFFF, 1'b1, 1'b0, "sll20_fill");
    serIn = 1'b0;
    load(16'h1234);
    start = 1'b1; mode = 3'd7; amount = 5'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || dataOut !== 16'h1234) begin
        bad++; $display("FAIL reserved_mode: got busy=%b done=%b data=%h exp 0/0/1234", busy, done, dataOut);
      end
      tick();
    end
  endtask

  task automatic test_abort;
    load(16'hF000);
    start = 1'b1; mode = 3'd3; amount = 5'd5;
    tick();
    start = 1'b1; mode = 3'd0; amount = 5'd1;
    tick();
    start = 1'b0;
    tick();
    total++;
    if (dataOut !== 16'hC003 || busy !== 1'b1) begin
      bad++; $display("FAIL abort_pre: got %h busy=%b exp c003 busy=1", dataOut, busy);
    end
    ld = 1'b1; dataIn = 16'h00FF;
    tick();
    ld = 1'b0;
    total++;
    if (dataOut !== 16'h00FF || busy !== 1'b0 || done !== 1'b0 || serOut !== 1'b1) begin
      bad++; $display("FAIL abort_ld: got %h/%b/%b/%b exp 00ff/0/0/1", dataOut, busy, done, serOut);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL abort_no_done: got done=%b busy=%b exp 0/0", done, busy);
      end
      tick();
    end
    last_ser = 1'b1;
  endtask

  task automatic test_legacy;
    serIn = 1'b0;
    load(16'h8001);
    shEn = 1'b1;
    tick();
    shEn = 1'b0;
    total++;
    if (dataOut !== 16'h0002 || serOut !== 1'b1) begin
      bad++; $display("FAIL legacy_shen: got %h/%b exp 0002/1", dataOut, serOut);
    end
    last_ser = 1'b1;
    load(16'h8001);
    run_op(3'd1, 5'd1, 16'h4000, 1'b1, 1'b1, "start_beats_shen");
  endtask

  task automatic test_back_to_back;
    load(16'h0003);
    start = 1'b1; mode = 3'd3; amount = 5'd1;
    tick();
    start = 1'b0;
    tick();
    total++;
    if (done !== 1'b1 || dataOut !== 16'h0006) begin
      bad++; $display("FAIL b2b_first: got done=%b data=%h exp 1/0006", done, dataOut);
    end
    start = 1'b1; mode = 3'd3; amount = 5'd3;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || dataOut !== 16'h0006) begin
      bad++; $display("FAIL start_in_done: got busy=%b done=%b data=%h exp 0/0/0006", busy, done, dataOut);
    end
    run_op(3'd3, 5'd1, 16'h000C, 1'b0, 1'b0, "b2b_second");
    run_op(3'd4, 5'd2, 16'h0003, 1'b0, 1'b0, "b2b_third");
  endtask

  task automatic test_random;
    logic [W-1:0] d;
    logic [W-1:0] ed;
    logic         es;
    logic [2:0]   m;
    int           n;
    for (int i = 0; i < 8; i++) begin
      d = W'($urandom);
      m = 3'($urandom_range(0, 4));
      n = int'($urandom_range(0, 20));
      serIn = 1'($urandom_range(0, 1));
      model_op(d, last_ser, m, n, serIn, ed, es);
      load(d);
      run_op(m, CW'(n), ed, es, 1'b0, "random");
    end
    serIn = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ld = 1'b0; dataIn = '0; shEn = 1'b0; start = 1'b0;
    mode = 3'd0; amount = '0; serIn = 1'b0; last_ser = 1'b0;
    test_reset();
    test_sll();
    test_ror_sra();
    test_boundary();
    test_abort();
    test_legacy();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
